axil_register_responder: RTL and testbench

AXI-Lite slave that terminates the `axi_lite` interface and exposes a bank of 32-bit control registers to the fabric. Write transactions update `output_registers` under byte strobes and pulse a per-register strobe; read transactions return live `input_registers` values. It is the responder for the AXI-Lite masters, typically the PS interconnect or bench bus drivers, and sits between the control bus and peripheral control/status ports.

---
 rtl/axil_responder_pkg.sv | 42 ++++
 rtl/axi_lite.sv | 42 ++++
 rtl/axil_write_collector.sv | 100 ++++++++++
 rtl/axil_register_responder.sv | 113 +++++++++++
 tb/tb_axil_register_responder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_responder_pkg.sv
// Shared types and helpers for the AXI-Lite register responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: response codes, write/read FSM state enums, and the address decode helper.
package axil_responder_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } write_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } read_state_t;

  // 8-bit index covers the largest supported bank of 256 registers.
  typedef struct packed {
    logic       valid;
    logic [7:0] index;
  } decode_t;

  // Byte address -> register index. The low two address bits are ignored.
  // Addresses below the base wrap to a huge offset, but the explicit
  // addr >= base term rejects them regardless.
  function automatic decode_t decode_address(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] n_registers);
    logic [31:0] offset;
    logic [31:0] word;
    decode_t     d;
    offset  = addr - base;
    word    = offset >> 2;
    d.valid = (addr >= base) && (word < n_registers);
    d.index = word[7:0];
    return d;
  endfunction

endpackage

// File: rtl/axi_lite.sv
// AXI-Lite bus bundle with master and slave views.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on each of the five channels.
// Ports: none; the AW, W, B, AR and R channel signals are exposed through the master and slave modports.
interface axi_lite #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_write_collector.sv
// Collects AXI-Lite AW and W beats (any order) and issues one register commit plus the B response.
// Latency: commit and BVALID on the edge where the second of AW/W handshakes.
// Backpressure: AW/W ready drop once their beat is held; nothing accepted until B handshakes.
// Ports: clock/reset; AW, W and B channel signals; commit/commit_index/commit_data/commit_strb to the register bank.
module axil_write_collector
  import axil_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int          N_REGISTERS  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] aw_addr,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_valid,
  output logic        w_ready,
  output logic [1:0]  b_resp,
  output logic        b_valid,
  input  logic        b_ready,
  output logic        commit,
  output logic [7:0]  commit_index,
  output logic [31:0] commit_data,
  output logic [3:0]  commit_strb
);

  write_state_t state;
  logic         aw_held;
  logic         w_held;
  logic [31:0]  aw_addr_q;
  logic [31:0]  w_data_q;
  logic [3:0]   w_strb_q;

  logic         aw_fire;
  logic         w_fire;
  logic         write_go;
  logic [31:0]  addr_cur;
  decode_t      dec;

  assign aw_ready = (state == W_IDLE) && !aw_held;
  assign w_ready  = (state == W_IDLE) && !w_held;
  assign aw_fire  = aw_valid && aw_ready;
  assign w_fire   = w_valid && w_ready;

  // A beat handshaking this cycle is used directly so the write lands on the
  // same edge as the last handshake rather than one cycle later.
  assign addr_cur    = aw_held ? aw_addr_q : aw_addr;
  assign commit_data = w_held ? w_data_q : w_data;
  assign commit_strb = w_held ? w_strb_q : w_strb;

  assign dec          = decode_address(addr_cur, BASE_ADDRESS, 32'(N_REGISTERS));
  assign write_go     = (state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign commit       = write_go && dec.valid;
  assign commit_index = dec.index;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid   <= 1'b0;
      b_resp    <= OKAY;
    end else begin
      unique case (state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= aw_addr;
          end
          if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= w_data;
            w_strb_q <= w_strb;
          end
          if (write_go) begin
            state   <= W_RESP;
            b_valid <= 1'b1;
            b_resp  <= dec.valid ? OKAY : SLVERR;
          end
        end
        W_RESP: begin
          // Held flags stay set here so both readies remain low until B completes.
          if (b_ready) begin
            state   <= W_IDLE;
            b_valid <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_register_responder.sv
// AXI-Lite slave exposing N 32-bit output registers (byte-strobed writes) and N live input registers (reads).
// Latency: write visible and BVALID one edge after AW+W; RVALID one edge after AR.
// Backpressure: one outstanding transaction per channel; BVALID/RVALID held until BREADY/RREADY.
// Ports: clock/reset, axil slave bus, input_registers (read-back), output_registers, write_strobe (1-cycle per-register pulse).
module axil_register_responder
  import axil_responder_pkg::*;
#(
  parameter logic [31:0]                   BASE_ADDRESS          = 32'h0,
  parameter int                            N_REGISTERS           = 8,
  parameter logic [N_REGISTERS-1:0][31:0]  INITIAL_OUTPUT_VALUES = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  axi_lite.slave                          axil,
  input  logic [N_REGISTERS-1:0][31:0]    input_registers,
  output logic [N_REGISTERS-1:0][31:0]    output_registers,
  output logic [N_REGISTERS-1:0]          write_strobe
);

  logic        commit;
  logic [7:0]  commit_index;
  logic [31:0] commit_data;
  logic [3:0]  commit_strb;

  axil_write_collector #(
    .BASE_ADDRESS (BASE_ADDRESS),
    .N_REGISTERS  (N_REGISTERS)
  ) u_write_collector (
    .clock        (clock),
    .reset        (reset),
    .aw_addr      (axil.awaddr),
    .aw_valid     (axil.awvalid),
    .aw_ready     (axil.awready),
    .w_data       (axil.wdata),
    .w_strb       (axil.wstrb),
    .w_valid      (axil.wvalid),
    .w_ready      (axil.wready),
    .b_resp       (axil.bresp),
    .b_valid      (axil.bvalid),
    .b_ready      (axil.bready),
    .commit       (commit),
    .commit_index (commit_index),
    .commit_data  (commit_data),
    .commit_strb  (commit_strb)
  );

  // Register bank. The strobe pulses on any committed write, including WSTRB=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      output_registers <= INITIAL_OUTPUT_VALUES;
      write_strobe     <= '0;
    end else begin
      write_strobe <= '0;
      for (int i = 0; i < N_REGISTERS; i++) begin
        if (commit && (commit_index == i[7:0])) begin
          write_strobe[i] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (commit_strb[b]) begin
              output_registers[i][b*8 +: 8] <= commit_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read path: independent of writes; always returns the live input value.
  read_state_t r_state;
  decode_t     rd_dec;
  logic [31:0] rd_word;
  logic        ar_fire;

  always_comb begin
    rd_dec  = decode_address(axil.araddr, BASE_ADDRESS, 32'(N_REGISTERS));
    rd_word = '0;
    for (int i = 0; i < N_REGISTERS; i++) begin
      if (rd_dec.index == i[7:0]) begin
        rd_word = input_registers[i];
      end
    end
  end

  assign axil.arready = (r_state == R_IDLE);
  assign ar_fire      = axil.arvalid && axil.arready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= R_IDLE;
      axil.rvalid <= 1'b0;
      axil.rresp  <= OKAY;
      axil.rdata  <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            r_state     <= R_DATA;
            axil.rvalid <= 1'b1;
            axil.rresp  <= rd_dec.valid ? OKAY : SLVERR;
            axil.rdata  <= rd_dec.valid ? rd_word : 32'h0;
          end
        end
        R_DATA: begin
          if (axil.rready) begin
            r_state     <= R_IDLE;
            axil.rvalid <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_register_responder.sv
// Scoreboard bench for axil_register_responder: directed AXI-Lite vectors,
// expected B/R responses queued at issue time and checked by a monitor.
module tb_axil_register_responder;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          N    = 8;
  localparam logic [7:0][31:0] INIT = {
    32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
    32'h3333_0003, 32'h2222_0002, 32'hAAAA_AAAA, 32'h1111_0000
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_lite #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axil ();

  logic [7:0][31:0] in_regs;
  logic [7:0][31:0] out_regs;
  logic [7:0][31:0] model;
  logic [7:0]       wstb;

  axil_register_responder #(
    .BASE_ADDRESS          (BASE),
    .N_REGISTERS           (N),
    .INITIAL_OUTPUT_VALUES (INIT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .axil             (axil),
    .input_registers  (in_regs),
    .output_registers (out_regs),
    .write_strobe     (wstb)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare every completed B/R handshake against the queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (axil.bvalid && axil.bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 1, 0);
        else check("bresp", axil.bresp, exp_b.pop_front());
      end
      if (axil.rvalid && axil.rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else check("rdata_rresp", {axil.rdata, axil.rresp}, exp_r.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    int t;
    t = 0;
    axil.awaddr  = a;
    axil.awvalid = 1'b1;
    @(negedge clock);
    while (!axil.awready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!axil.awready) check("aw_timeout", 0, 1);
    else tick();
    axil.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int t;
    t = 0;
    axil.wdata  = d;
    axil.wstrb  = s;
    axil.wvalid = 1'b1;
    @(negedge clock);
    while (!axil.wready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!axil.wready) check("w_timeout", 0, 1);
    else tick();
    axil.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int t;
    t = 0;
    axil.araddr  = a;
    axil.arvalid = 1'b1;
    @(negedge clock);
    while (!axil.arready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!axil.arready) check("ar_timeout", 0, 1);
    else tick();
    axil.arvalid = 1'b0;
  endtask

  task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axil.awaddr = '0; axil.awvalid = 0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 0;
    axil.bready = 1;
    axil.araddr = '0; axil.arvalid = 0;
    axil.rready = 1;
    in_regs = '0;
    model   = INIT;

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_readys", {axil.awready, axil.wready, axil.arready}, 3'b111);
    check("rst_valids", {axil.bvalid, axil.rvalid}, 2'b00);
    check("rst_resps", {axil.bresp, axil.rresp}, 4'b0000);
    check("rst_rdata", axil.rdata, 32'h0);
    check("rst_strobe", wstb, 8'h00);
    check("rst_regs", out_regs, INIT);
    tick();
    reset = 1'b0;
    tick();

    // 1: simultaneous AW/W
    exp_b.push_back(2'b00);
    model[2] = 32'hDEAD_BEEF;
    write_both(BASE + 8, 32'hDEAD_BEEF, 4'hF);
    @(negedge clock);
    check("t1_reg2", out_regs[2], 32'hDEAD_BEEF);
    check("t1_strobe", wstb, 8'h04);
    check("t1_regs", out_regs, model);
    check("t1_bvalid", axil.bvalid, 1'b1);
    check("t1_rdy_low", {axil.awready, axil.wready}, 2'b00);
    @(negedge clock);
    check("t1_strobe_clr", wstb, 8'h00);
    check("t1_rdy_back", {axil.awready, axil.wready}, 2'b11);
    tick();

    // 2: W three cycles ahead of AW, partial strobes
    exp_b.push_back(2'b00);
    model[1] = 32'hAA34_AA78;
    fork
      send_w(32'h1234_5678, 4'b0101);
      begin
        repeat (3) @(posedge clock);
        #1;
        send_aw(BASE + 4);
      end
      begin
        @(negedge clock);
        repeat (3) begin
          @(negedge clock);
          check("t2_wready_low", axil.wready, 1'b0);
          check("t2_awready_high", axil.awready, 1'b1);
        end
      end
    join
    @(negedge clock);
    check("t2_reg1", out_regs[1], 32'hAA34_AA78);
    check("t2_strobe", wstb, 8'h02);
    check("t2_regs", out_regs, model);
    tick();

    // 3: out of range above, below base, last register with WSTRB=0
    exp_b.push_back(2'b10);
    write_both(BASE + 32, 32'hFFFF_FFFF, 4'hF);
    @(negedge clock);
    check("t3_hi_strobe", wstb, 8'h00);
    check("t3_hi_regs", out_regs, model);
    tick();
    exp_b.push_back(2'b10);
    write_both(BASE - 4, 32'hFFFF_FFFF, 4'hF);
    @(negedge clock);
    check("t3_lo_strobe", wstb, 8'h00);
    check("t3_lo_regs", out_regs, model);
    tick();
    exp_b.push_back(2'b00);
    write_both(BASE + 30, 32'h1234_5678, 4'h0);
    @(negedge clock);
    check("t3_last_strobe", wstb, 8'h80);
    check("t3_last_regs", out_regs, model);
    tick();

    // 4: BREADY low for 5 cycles
    axil.bready = 1'b0;
    exp_b.push_back(2'b00);
    model[0] = 32'h1111_00F0;
    write_both(BASE, 32'h0000_00F0, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("t4_bvalid", axil.bvalid, 1'b1);
      check("t4_bresp", axil.bresp, 2'b00);
      check("t4_rdy_low", {axil.awready, axil.wready}, 2'b00);
    end
    tick();
    axil.bready = 1'b1;
    @(negedge clock);
    check("t4_rdy_hs_cycle", {axil.awready, axil.wready}, 2'b00);
    @(negedge clock);
    check("t4_rdy_back", {axil.awready, axil.wready, axil.bvalid}, 3'b110);
    check("t4_regs", out_regs, model);
    tick();

    // 5: read with RREADY low, sampled at AR edge; then out-of-range read
    in_regs[3] = 32'hCAFE_0001;
    axil.rready = 1'b0;
    exp_r.push_back({32'hCAFE_0001, 2'b00});
    send_ar(BASE + 12);
    in_regs[3] = 32'h0BAD_0BAD;
    repeat (2) begin
      @(negedge clock);
      check("t5_rvalid", axil.rvalid, 1'b1);
      check("t5_rdata", axil.rdata, 32'hCAFE_0001);
      check("t5_rresp", axil.rresp, 2'b00);
      check("t5_arready_low", axil.arready, 1'b0);
    end
    tick();
    axil.rready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t5_ar_back", {axil.arready, axil.rvalid}, 2'b10);
    tick();
    exp_r.push_back({32'h0, 2'b10});
    send_ar(BASE + 32);
    @(negedge clock);
    check("t5_oor_rvalid", axil.rvalid, 1'b1);
    tick();

    // 6: concurrent read and write to the same index
    in_regs[5] = 32'h5EED_5EED;
    model[5] = 32'h9999_9999;
    exp_b.push_back(2'b00);
    exp_r.push_back({32'h5EED_5EED, 2'b00});
    fork
      send_aw(BASE + 20);
      send_w(32'h9999_9999, 4'hF);
      send_ar(BASE + 20);
    join
    @(negedge clock);
    check("t6_reg5", out_regs[5], 32'h9999_9999);
    check("t6_strobe", wstb, 8'h20);
    tick();

    // 7: reset while B and R are pending
    axil.bready = 1'b0;
    axil.rready = 1'b0;
    fork
      send_aw(BASE + 8);
      send_w(32'h0102_0304, 4'hF);
      send_ar(BASE + 4);
    join
    reset = 1'b1;
    @(negedge clock);
    check("t7_pending", {axil.bvalid, axil.rvalid}, 2'b11);
    @(negedge clock);
    check("t7_valids", {axil.bvalid, axil.rvalid}, 2'b00);
    check("t7_readys", {axil.awready, axil.wready, axil.arready}, 3'b111);
    check("t7_regs", out_regs, INIT);
    check("t7_strobe", wstb, 8'h00);
    model = INIT;
    tick();
    reset = 1'b0;
    axil.bready = 1'b1;
    axil.rready = 1'b1;
    tick();

    // Traffic after reset
    in_regs[7] = 32'h7070_7070;
    model[7] = 32'hFEED_FACE;
    exp_b.push_back(2'b00);
    exp_r.push_back({32'h7070_7070, 2'b00});
    fork
      send_aw(BASE + 28);
      send_w(32'hFEED_FACE, 4'hF);
      send_ar(BASE + 28);
    join
    @(negedge clock);
    check("t8_regs", out_regs, model);
    repeat (3) tick();

    check("b_queue_drained", exp_b.size(), 0);
    check("r_queue_drained", exp_r.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
